// File: rtl/div_unit_pkg.sv
// -----------------------------------------------------------------------------
// div_unit_pkg -- shared core definitions.
//
// Holds the ALU op constants, the M-extension divide op encodings (funct3[1:0])
// and the divider FSM state encoding, plus small op-decoding helpers.
// No ports; imported by div_unit and div_step.
// -----------------------------------------------------------------------------
package div_unit_pkg;

    // ALU op constants used by the EX stage.
    localparam logic [3:0] ALU_ADD  = 4'h0;
    localparam logic [3:0] ALU_SUB  = 4'h1;
    localparam logic [3:0] ALU_AND  = 4'h2;
    localparam logic [3:0] ALU_OR   = 4'h3;
    localparam logic [3:0] ALU_XOR  = 4'h4;
    localparam logic [3:0] ALU_SLL  = 4'h5;
    localparam logic [3:0] ALU_SRL  = 4'h6;
    localparam logic [3:0] ALU_SRA  = 4'h7;
    localparam logic [3:0] ALU_SLT  = 4'h8;
    localparam logic [3:0] ALU_SLTU = 4'h9;

    // Divide/remainder ops, encoded as funct3[1:0].
    localparam logic [1:0] DIV_OP_DIV  = 2'b00;
    localparam logic [1:0] DIV_OP_DIVU = 2'b01;
    localparam logic [1:0] DIV_OP_REM  = 2'b10;
    localparam logic [1:0] DIV_OP_REMU = 2'b11;

    // Divider FSM states.
    localparam logic [1:0] DIV_ST_IDLE = 2'd0;
    localparam logic [1:0] DIV_ST_CALC = 2'd1;
    localparam logic [1:0] DIV_ST_DONE = 2'd2;

    function automatic logic div_op_is_signed(input logic [1:0] op);
        return (op == DIV_OP_DIV) || (op == DIV_OP_REM);
    endfunction

    function automatic logic div_op_is_rem(input logic [1:0] op);
        return (op == DIV_OP_REM) || (op == DIV_OP_REMU);
    endfunction

endpackage

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step -- one restoring shift-subtract iteration (purely combinational).
//
// The dividend magnitude lives in quo_in and is shifted out MSB-first into the
// partial remainder while quotient bits are shifted in at the LSB.
//
// Ports:
//   rem_in   [XLEN-1:0]  partial remainder before the step
//   quo_in   [XLEN-1:0]  remaining dividend bits / quotient bits so far
//   divisor  [XLEN-1:0]  divisor magnitude
//   rem_out  [XLEN-1:0]  partial remainder after the step
//   quo_out  [XLEN-1:0]  quo_in shifted left with the new quotient bit
// -----------------------------------------------------------------------------
module div_step
    import div_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem_in,
    input  logic [XLEN-1:0] quo_in,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_out,
    output logic [XLEN-1:0] quo_out
);

    logic [XLEN:0]   shifted;
    logic [XLEN-1:0] diff;
    logic            no_borrow;

    always_comb begin
        shifted   = {rem_in, quo_in[XLEN-1]};
        no_borrow = (shifted >= {1'b0, divisor});
        // When the subtraction succeeds the true difference is below the
        // divisor, so the low XLEN bits hold it exactly.
        diff      = shifted[XLEN-1:0] - divisor;
        rem_out   = no_borrow ? diff : shifted[XLEN-1:0];
        quo_out   = {quo_in[XLEN-2:0], no_borrow};
    end

endmodule

// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit -- iterative RV32M divide/remainder unit (DIV, DIVU, REM, REMU).
//
// A restoring divider on operand magnitudes: one div_step per CALC cycle for
// XLEN cycles, then a single DONE cycle that applies the sign fix-up and the
// divide-by-zero / signed-overflow results and pulses valid.
//
// Build option: define DIV_UNIT_EARLY_OUT_EN to let divide-by-zero, signed
// overflow and |dividend| < |divisor| jump straight from IDLE to DONE.
//
// Ports:
//   clk                    rising-edge clock
//   rst                    synchronous active-high reset
//   start                  request an operation (ignored while busy)
//   flush                  kill any operation in progress
//   op        [1:0]        funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   dividend  [XLEN-1:0]   rs1
//   divisor   [XLEN-1:0]   rs2
//   busy                   high while an operation is held (stalls EX)
//   valid                  one-cycle result strobe
//   result    [XLEN-1:0]   quotient or remainder, zero outside the DONE cycle
// -----------------------------------------------------------------------------
module div_unit
    import div_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            flush,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            busy,
    output logic            valid,
    output logic [XLEN-1:0] result
);

    localparam int              CNT_W    = $clog2(XLEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;
    logic [XLEN-1:0]  quo_q, quo_d;
    logic [XLEN-1:0]  rem_q, rem_d;
    logic [XLEN-1:0]  dvs_q, dvs_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic             dz_q, dz_d;
    logic             ovf_q, ovf_d;

    logic [XLEN-1:0]  step_rem, step_quo;

    // Operand decode for the request presented this cycle.
    logic             in_signed, a_neg, b_neg, in_dz, in_ovf;
    logic [XLEN-1:0]  a_mag, b_mag;

    always_comb begin
        in_signed = div_op_is_signed(op);
        a_neg     = in_signed & dividend[XLEN-1];
        b_neg     = in_signed & divisor[XLEN-1];
        a_mag     = a_neg ? (~dividend + 1'b1) : dividend;
        b_mag     = b_neg ? (~divisor + 1'b1) : divisor;
        in_dz     = (divisor == '0);
        in_ovf    = in_signed & (dividend == INT_MIN) & (divisor == '1);
    end

    div_step #(
        .XLEN    (XLEN)
    ) u_step (
        .rem_in  (rem_q),
        .quo_in  (quo_q),
        .divisor (dvs_q),
        .rem_out (step_rem),
        .quo_out (step_quo)
    );

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        dz_d    = dz_q;
        ovf_d   = ovf_q;

        case (state_q)
            DIV_ST_IDLE: begin
                if (start) begin
                    op_d    = op;
                    quo_d   = a_mag;   // dividend bits are shifted out of here
                    rem_d   = '0;
                    dvs_d   = b_mag;
                    q_neg_d = a_neg ^ b_neg;
                    r_neg_d = a_neg;
                    dz_d    = in_dz;
                    ovf_d   = in_ovf;
                    cnt_d   = '0;
                    state_d = DIV_ST_CALC;
`ifdef DIV_UNIT_EARLY_OUT_EN
                    // Results known up front: load final magnitudes and let
                    // DONE apply the usual fix-up.
                    if (in_dz || in_ovf || (a_mag < b_mag)) begin
                        quo_d   = in_ovf ? a_mag : '0;
                        rem_d   = in_ovf ? '0 : a_mag;
                        state_d = DIV_ST_DONE;
                    end
`endif
                end
            end
            DIV_ST_CALC: begin
                quo_d = step_quo;
                rem_d = step_rem;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = DIV_ST_DONE;
                end
            end
            DIV_ST_DONE: begin
                state_d = DIV_ST_IDLE;
            end
            default: begin
                state_d = DIV_ST_IDLE;
            end
        endcase

        // Flush beats a simultaneous start and aborts any operation.
        if (flush) begin
            state_d = DIV_ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: the datapath registers are reset along with the control state
        // so a reset leaves no stale operands or partial results behind.
        if (rst) begin
            state_q <= DIV_ST_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            dz_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments for all state, so every flop
            // samples the values computed before this edge.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            dz_q    <= dz_d;
            ovf_q   <= ovf_d;
        end
    end

    // Sign fix-up and special-case results, applied in DONE.
    logic [XLEN-1:0] q_fix, r_fix;

    always_comb begin
        if (dz_q) begin
            q_fix = '1;
        end else if (ovf_q) begin
            q_fix = INT_MIN;
        end else begin
            q_fix = q_neg_q ? (~quo_q + 1'b1) : quo_q;
        end

        // Divide-by-zero leaves |dividend| in rem_q, so restoring the
        // dividend's sign reproduces the original dividend.
        if (ovf_q) begin
            r_fix = '0;
        end else begin
            r_fix = r_neg_q ? (~rem_q + 1'b1) : rem_q;
        end
    end

    always_comb begin
        busy   = (state_q != DIV_ST_IDLE);
        valid  = (state_q == DIV_ST_DONE);
        result = '0;
        if (valid) begin
            result = div_op_is_rem(op_q) ? r_fix : q_fix;
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// -----------------------------------------------------------------------------
// tb_div_unit -- self-checking bench for div_unit.
//
// Directed vectors with hand-computed results and latencies, plus a
// transaction-level reference model (arithmetic results and a countdown to the
// result strobe) compared against busy/valid/result on every falling edge.
// Honours DIV_UNIT_EARLY_OUT_EN for the expected latency.
// -----------------------------------------------------------------------------
module tb_div_unit;

`ifdef DIV_UNIT_EARLY_OUT_EN
    localparam bit EARLY_EN = 1'b1;
`else
    localparam bit EARLY_EN = 1'b0;
`endif
    localparam int FULL_LAT  = 33;
    localparam int EARLY_LAT = EARLY_EN ? 1 : FULL_LAT;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    logic        clk;
    logic        rst;
    logic        start;
    logic        flush;
    logic [1:0]  op;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        valid;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    div_unit #(
        .XLEN     (32)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .flush    (flush),
        .op       (op),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .valid    (valid),
        .result   (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_div(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
        bit is_signed = (f == OP_DIV) || (f == OP_REM);
        bit is_rem    = (f == OP_REM) || (f == OP_REMU);
        if (b == 32'd0) return is_rem ? a : 32'hFFFF_FFFF;
        if (is_signed && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return is_rem ? 32'd0 : 32'h8000_0000;
        if (is_signed) return is_rem ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
        return is_rem ? (a % b) : (a / b);
    endfunction

    function automatic int ref_lat(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
        bit     is_signed = (f == OP_DIV) || (f == OP_REM);
        longint ma, mb;
        bit     special;
        ma = is_signed ? longint'($signed(a)) : longint'(a);
        mb = is_signed ? longint'($signed(b)) : longint'(b);
        if (ma < 0) ma = -ma;
        if (mb < 0) mb = -mb;
        special = (b == 32'd0) || (ma < mb) ||
                  (is_signed && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
        return (EARLY_EN && special) ? 1 : FULL_LAT;
    endfunction

    // m_left: cycles remaining until (and including) the valid cycle; 0 = idle.
    int          m_left = 0;
    logic [31:0] m_res  = 32'd0;
    bit          model_ready = 1'b0;

    always @(posedge clk) begin
        model_ready <= 1'b1;
        if (rst)              m_left <= 0;
        else if (flush)       m_left <= 0;
        else if (m_left > 0)  m_left <= m_left - 1;
        else if (start) begin
            m_left <= ref_lat(op, dividend, divisor);
            m_res  <= ref_div(op, dividend, divisor);
        end
    end

    always @(negedge clk) begin
        if (model_ready) begin
            check("busy",   32'(busy),  32'(m_left > 0));
            check("valid",  32'(valid), 32'(m_left == 1));
            check("result", result,     (m_left == 1) ? m_res : 32'd0);
        end
    end

    // ---------------- stimulus helpers ----------------
    // Called at a falling edge: presents a request for one cycle (cycle 0) and
    // returns at the falling edge of cycle 1.
    task automatic issue(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
        op       = f;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    // Waits (bounded) for valid; cyc is the cycle number relative to the start.
    task automatic wait_result(input string name, input int start_cyc,
                               input logic [31:0] exp, input int lat);
        int cyc  = start_cyc;
        bit seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (valid) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
            cyc++;
        end
        check({name, "_seen"}, 32'(seen), 32'd1);
        check({name, "_lat"},  32'(cyc),  32'(lat));
        check({name, "_res"},  result,    exp);
    endtask

    typedef struct {
        string       name;
        logic [1:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int vcount;

        vecs.push_back('{"divu_100_7",   OP_DIVU, 32'd100,        32'd7,          32'd14,         FULL_LAT});
        vecs.push_back('{"remu_100_7",   OP_REMU, 32'd100,        32'd7,          32'd2,          FULL_LAT});
        vecs.push_back('{"div_m7_2",     OP_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  FULL_LAT});
        vecs.push_back('{"rem_m7_2",     OP_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  FULL_LAT});
        vecs.push_back('{"div_50_m2028", OP_DIV,  32'd50,         32'hFFFF_F814,  32'd0,          EARLY_LAT});
        vecs.push_back('{"rem_50_m2028", OP_REM,  32'd50,         32'hFFFF_F814,  32'd50,         EARLY_LAT});
        vecs.push_back('{"div_50_0",     OP_DIV,  32'd50,         32'd0,          32'hFFFF_FFFF,  EARLY_LAT});
        vecs.push_back('{"rem_50_0",     OP_REM,  32'd50,         32'd0,          32'd50,         EARLY_LAT});
        vecs.push_back('{"div_ovf",      OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  EARLY_LAT});
        vecs.push_back('{"rem_ovf",      OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          EARLY_LAT});
        vecs.push_back('{"divu_min_m1",  OP_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          EARLY_LAT});
        vecs.push_back('{"remu_min_m1",  OP_REMU, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  EARLY_LAT});
        vecs.push_back('{"div_m100_7",   OP_DIV,  32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  FULL_LAT});
        vecs.push_back('{"rem_m100_7",   OP_REM,  32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFFE,  FULL_LAT});
        vecs.push_back('{"div_100_m7",   OP_DIV,  32'd100,        32'hFFFF_FFF9,  32'hFFFF_FFF2,  FULL_LAT});
        vecs.push_back('{"rem_100_m7",   OP_REM,  32'd100,        32'hFFFF_FFF9,  32'd2,          FULL_LAT});
        vecs.push_back('{"div_m7_0",     OP_DIV,  32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFFF,  EARLY_LAT});
        vecs.push_back('{"rem_m7_0",     OP_REM,  32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFF9,  EARLY_LAT});
        vecs.push_back('{"divu_max_1",   OP_DIVU, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  FULL_LAT});
        vecs.push_back('{"divu_dead",    OP_DIVU, 32'hDEAD_BEEF,  32'h0001_0000,  32'h0000_DEAD,  FULL_LAT});
        vecs.push_back('{"remu_beef",    OP_REMU, 32'hDEAD_BEEF,  32'h0001_0000,  32'h0000_BEEF,  FULL_LAT});
        vecs.push_back('{"remu_0_0",     OP_REMU, 32'd0,          32'd0,          32'd0,          EARLY_LAT});

        rst      = 1'b1;
        start    = 1'b0;
        flush    = 1'b0;
        op       = 2'b00;
        dividend = 32'd0;
        divisor  = 32'd0;
        repeat (3) @(negedge clk);
        check("reset_busy",   32'(busy),  32'd0);
        check("reset_valid",  32'(valid), 32'd0);
        check("reset_result", result,     32'd0);
        rst = 1'b0;

        // Pin the model to the hand-computed values.
        foreach (vecs[i]) begin
            check({vecs[i].name, "_model"}, ref_div(vecs[i].f, vecs[i].a, vecs[i].b), vecs[i].exp);
            check({vecs[i].name, "_model_lat"}, 32'(ref_lat(vecs[i].f, vecs[i].a, vecs[i].b)), 32'(vecs[i].lat));
        end

        // Directed vectors, issued back-to-back (start in the cycle after DONE).
        vcount = vecs.size();
        @(negedge clk);
        for (int i = 0; i < vcount; i++) begin
            issue(vecs[i].f, vecs[i].a, vecs[i].b);
            wait_result(vecs[i].name, 1, vecs[i].exp, vecs[i].lat);
            @(negedge clk);
        end
        repeat (2) @(negedge clk);

        // Flush in cycle 10, restart in cycle 11.
        issue(OP_DIVU, 32'd1000, 32'd3);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy",  32'(busy),  32'd0);
        check("flush_valid", 32'(valid), 32'd0);
        issue(OP_DIVU, 32'd1000, 32'd3);
        wait_result("after_flush", 1, 32'd333, FULL_LAT);
        repeat (2) @(negedge clk);

        // Second start in cycle 5 is ignored.
        issue(OP_DIVU, 32'd100, 32'd7);
        repeat (4) @(negedge clk);
        op       = OP_REMU;
        dividend = 32'd555;
        divisor  = 32'd2;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        wait_result("ignored_start", 6, 32'd14, FULL_LAT);
        repeat (2) @(negedge clk);

        // Flush wins over a simultaneous start.
        op = OP_DIVU; dividend = 32'd9; divisor = 32'd3;
        start = 1'b1; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("flush_prio_busy", 32'(busy), 32'd0);

        // Reset wins over flush and start.
        start = 1'b1; flush = 1'b1; rst = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0; rst = 1'b0;
        check("rst_prio_busy", 32'(busy), 32'd0);
        @(negedge clk);

        // Reset in cycle 20 of an operation.
        issue(OP_DIVU, 32'd12345, 32'd67);
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy",   32'(busy),  32'd0);
        check("midrst_valid",  32'(valid), 32'd0);
        check("midrst_result", result,     32'd0);
        begin
            int pulses = 0;
            for (int i = 0; i < 40; i++) begin
                if (valid) pulses++;
                @(negedge clk);
            end
            check("midrst_no_valid", 32'(pulses), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have the parameter XLEN, default 32, giving the operand and result width.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port start, input, 1 bit: the EX stage requests a divide/remainder operation.
REQ-005 SHALL have port flush, input, 1 bit: pipeline flush that kills any operation in progress.
REQ-006 SHALL have port op, input, 2 bits: M-extension funct3[1:0], where 00=DIV, 01=DIVU, 10=REM, 11=REMU.
REQ-007 SHALL have port dividend, input, XLEN bits: rs1 value.
REQ-008 SHALL have port divisor, input, XLEN bits: rs2 value.
REQ-009 SHALL have port busy, output, 1 bit: high while an operation is held; the EX stage stalls the pipeline on it.
REQ-010 SHALL have port valid, output, 1 bit: one-cycle pulse marking result as valid.
REQ-011 SHALL have port result, output, XLEN bits: quotient or remainder, as selected by op.

Function
REQ-012 SHALL implement the states IDLE, CALC and DONE; busy = (state != IDLE).
REQ-013 In IDLE with start=1 and flush=0, SHALL latch op, operand magnitudes and sign flags, clear the iteration counter, and move to CALC.
REQ-014 SHALL ignore start while busy=1; latched operands SHALL NOT change.
REQ-015 In CALC, SHALL perform one restoring shift-subtract step per cycle for exactly XLEN cycles, then move to DONE.
REQ-016 In DONE, SHALL assert valid for exactly one cycle with result stable, then return to IDLE.
REQ-017 Latency: with start sampled in cycle 0, valid SHALL be high in cycle XLEN+1 (cycle 33); busy SHALL be high in cycles 1..33.
REQ-018 Signed ops SHALL divide magnitudes; the quotient SHALL be negated when the operand signs differ, and the remainder SHALL take the dividend's sign.
REQ-019 Divisor=0 SHALL give quotient all-ones and remainder = dividend, for both signed and unsigned ops.
REQ-020 DIV/REM of 0x80000000 by 0xFFFFFFFF SHALL give quotient 0x80000000 and remainder 0.
REQ-021 flush=1 in any state SHALL force IDLE at the next edge, with no valid pulse; flush SHALL take priority over a simultaneous start.
REQ-022 valid and result SHALL be 0 in every cycle other than the DONE cycle.
REQ-023 Back-to-back: a start in the cycle after DONE SHALL be accepted normally.

Reset
REQ-024 rst=1 SHALL force IDLE at the next edge, including mid-operation, and SHALL set busy=0, valid=0, result=0, and the counter and datapath registers to 0.
REQ-025 rst SHALL take priority over flush and start.

Configuration
REQ-026 With DIV_UNIT_EARLY_OUT_EN defined:
- divisor=0, signed overflow, or |dividend| < |divisor| SHALL go from IDLE directly to DONE.
- valid SHALL then be high in cycle 1.
- results SHALL be as in REQ-018 to REQ-020.
REQ-027 Without DIV_UNIT_EARLY_OUT_EN, every operation SHALL take the full REQ-017 latency.
- Special-case results SHALL still be corrected in DONE so they match REQ-019 and REQ-020.

Structure
REQ-028 The op encodings (DIV, DIVU, REM, REMU) and the state encoding SHALL live in the shared core definitions package, alongside the existing ALU op constants.
REQ-029 One combinational sub-module, div_step, SHALL compute a single shift-subtract iteration (partial remainder, quotient bit); div_unit SHALL own the FSM, counter and sign fix-up.

Verification
REQ-030 DIVU 100/7 started in cycle 0 -> valid in cycle 33, result 14; REMU 100/7 -> 2.
REQ-031 DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIV 50 / -2028 -> 0.
REQ-032 DIV 50/0 -> 0xFFFFFFFF; REM 50/0 -> 50; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0.
- Latency SHALL be 1 cycle with DIV_UNIT_EARLY_OUT_EN and 33 cycles without.
REQ-033 flush in cycle 10 of a DIVU -> busy low in cycle 11, no valid pulse; a start in cycle 11 completes with the correct result.
REQ-034 A second start with different operands in cycle 5 -> ignored; the first result is delivered unchanged in cycle 33.
REQ-035 rst asserted in cycle 20 -> IDLE and all outputs 0 from cycle 21; no valid pulse follows.
